fifo_write: RTL and testbench

Write-side controller of the asynchronous FIFO, in the wclk domain.
- Accepts write requests and advances a binary/Gray write pointer when winc && !wfull.
- Supplies the RAM write address and write enable.
- Synchronizes the read domain's Gray read pointer with an internal 2-flop stage, then derives registered wfull, walmost_full, a fill count and a sticky overflow flag.

---
 rtl/fifo_pkg.sv | 22 ++
 rtl/fifo_write_if.sv | 25 ++
 rtl/sync_2ff.sv | 25 ++
 rtl/fifo_write.sv | 79 +++++++
 tb/tb_fifo_write.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and Gray/binary conversion helpers for the asynchronous FIFO.
// The helpers work on zero-extended values, so any pointer width up to 32 bits is handled.
package fifo_pkg;

    localparam int ADDRSIZE_DEF = 4;
    localparam int DEPTH_DEF    = 1 << ADDRSIZE_DEF;

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_write_if.sv
// Write-side bus of the asynchronous FIFO: request/clear in, pointer and status out.
interface fifo_write_if #(
    parameter int ADDRSIZE = 4
);
    logic                winc;
    logic                wovf_clr;
    logic [ADDRSIZE:0]   rptr;
    logic                wclken;
    logic [ADDRSIZE-1:0] waddr;
    logic [ADDRSIZE:0]   wptr;
    logic                wfull;
    logic                walmost_full;
    logic [ADDRSIZE:0]   wfill;
    logic                woverflow;

    modport master (
        output winc, wovf_clr, rptr,
        input  wclken, waddr, wptr, wfull, walmost_full, wfill, woverflow
    );

    modport slave (
        input  winc, wovf_clr, rptr,
        output wclken, waddr, wptr, wfull, walmost_full, wfill, woverflow
    );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a Gray-coded pointer crossing into this clock domain.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] q1_q;
    logic [WIDTH-1:0] q2_q;

    // Metastability stage followed by the stable output stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q1_q <= {WIDTH{1'b0}};
            q2_q <= {WIDTH{1'b0}};
        end else begin
            q1_q <= d;
            q2_q <= q1_q;
        end
    end

    assign q = q2_q;
endmodule

// File: rtl/fifo_write.sv
// Write-domain controller of the asynchronous FIFO: pointer generation, RAM write
// strobe, and registered full / almost-full / fill / overflow status.
module fifo_write
    import fifo_pkg::*;
#(
    parameter int ADDRSIZE              = ADDRSIZE_DEF,
    parameter int ALMOST_FULL_THRESHOLD = 4
) (
    input  logic         wclk,
    input  logic         wrst_n,
    fifo_write_if.slave  bus
);
    localparam int              PW       = ADDRSIZE + 1;
    localparam int              DEPTH    = 1 << ADDRSIZE;
    localparam logic [PW-1:0]   AF_LEVEL = PW'(DEPTH - ALMOST_FULL_THRESHOLD);

    logic [PW-1:0] wbin_q,         wbin_d;
    logic [PW-1:0] wptr_q,         wptr_d;
    logic [PW-1:0] wfill_q,        wfill_d;
    logic          wfull_q,        wfull_d;
    logic          walmost_full_q, walmost_full_d;
    logic          woverflow_q,    woverflow_d;
    logic          wclken_s;
    logic [PW-1:0] wq2_rptr_s;
    logic [PW-1:0] rbin_sync_s;

    sync_2ff #(.WIDTH(PW)) sync_r2w (
        .clk   (wclk),
        .rst_n (wrst_n),
        .d     (bus.rptr),
        .q     (wq2_rptr_s)
    );

    // Next pointer and status; status is computed from the post-write pointer so
    // wfull rises on the same edge that accepts the last free slot.
    always_comb begin
        wclken_s       = bus.winc & ~wfull_q;
        wbin_d         = wbin_q + {{ADDRSIZE{1'b0}}, wclken_s};
        wptr_d         = PW'(bin2gray(32'(wbin_d)));
        rbin_sync_s    = PW'(gray2bin(32'(wq2_rptr_s)));
        wfull_d        = (wptr_d == {~wq2_rptr_s[ADDRSIZE:ADDRSIZE-1], wq2_rptr_s[ADDRSIZE-2:0]});
        wfill_d        = wbin_d - rbin_sync_s;
        walmost_full_d = (wfill_d >= AF_LEVEL);
        if (bus.winc && wfull_q) begin
            woverflow_d = 1'b1;
        end else if (bus.wovf_clr) begin
            woverflow_d = 1'b0;
        end else begin
            woverflow_d = woverflow_q;
        end
    end

    // Write-domain state registers.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin_q         <= {PW{1'b0}};
            wptr_q         <= {PW{1'b0}};
            wfill_q        <= {PW{1'b0}};
            wfull_q        <= 1'b0;
            walmost_full_q <= 1'b0;
            woverflow_q    <= 1'b0;
        end else begin
            wbin_q         <= wbin_d;
            wptr_q         <= wptr_d;
            wfill_q        <= wfill_d;
            wfull_q        <= wfull_d;
            walmost_full_q <= walmost_full_d;
            woverflow_q    <= woverflow_d;
        end
    end

    assign bus.wclken       = wclken_s;
    assign bus.waddr        = wbin_q[ADDRSIZE-1:0];
    assign bus.wptr         = wptr_q;
    assign bus.wfull        = wfull_q;
    assign bus.walmost_full = walmost_full_q;
    assign bus.wfill        = wfill_q;
    assign bus.woverflow    = woverflow_q;
endmodule

// File: tb/tb_fifo_write.sv
// Directed bench for fifo_write: vector table for fill/full/overflow/read-release,
// plus hand sequences for async reset and a long wrapping burst.
module tb_fifo_write;
    logic wclk;
    logic wrst_n;
    int   checks;
    int   failures;

    fifo_write_if #(.ADDRSIZE(4)) bus ();

    fifo_write #(.ADDRSIZE(4), .ALMOST_FULL_THRESHOLD(4)) dut (
        .wclk   (wclk),
        .wrst_n (wrst_n),
        .bus    (bus)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    typedef struct {
        logic       winc;
        logic       clr;
        logic [4:0] rptr;
        logic       en;
        logic [3:0] addr;
        logic [4:0] wptr;
        logic       full;
        logic       alm;
        logic [4:0] fill;
        logic       ovf;
    } vec_t;

    vec_t vecs [24];

    function automatic vec_t mk(logic winc, logic clr, logic [4:0] rptr, logic en,
                                logic [3:0] addr, logic [4:0] wptr, logic full,
                                logic alm, logic [4:0] fill, logic ovf);
        vec_t v;
        v.winc = winc; v.clr = clr; v.rptr = rptr; v.en = en; v.addr = addr;
        v.wptr = wptr; v.full = full; v.alm = alm; v.fill = fill; v.ovf = ovf;
        return v;
    endfunction

    function automatic logic [4:0] tb_gray(input logic [4:0] b);
        return b ^ {1'b0, b[4:1]};
    endfunction

    function automatic logic [4:0] tb_g2b(input logic [4:0] g);
        logic [4:0] b;
        logic       acc;
        acc = 1'b0;
        for (int i = 4; i >= 0; i--) begin
            acc  = acc ^ g[i];
            b[i] = acc;
        end
        return b;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_regs(input string tag, input logic [4:0] wptr, input logic full,
                            input logic alm, input logic [4:0] fill, input logic ovf);
        chk({tag, " wptr"},  32'(bus.wptr),         32'(wptr));
        chk({tag, " wfull"}, 32'(bus.wfull),        32'(full));
        chk({tag, " walm"},  32'(bus.walmost_full), 32'(alm));
        chk({tag, " wfill"}, 32'(bus.wfill),        32'(fill));
        chk({tag, " wovf"},  32'(bus.woverflow),    32'(ovf));
    endtask

    initial begin
        logic [4:0] prev;
        logic [4:0] cur;
        int         rd;
        int         exp_fill;

        checks = 0;
        failures = 0;

        // Fill to full from empty with the reader idle.
        vecs[0]  = mk(1'b1, 1'b0, 5'd0, 1'b1, 4'd0,  5'b00001, 1'b0, 1'b0, 5'd1,  1'b0);
        vecs[1]  = mk(1'b1, 1'b0, 5'd0, 1'b1, 4'd1,  5'b00011, 1'b0, 1'b0, 5'd2,  1'b0);
        vecs[2]  = mk(1'b1, 1'b0, 5'd0, 1'b1, 4'd2,  5'b00010, 1'b0, 1'b0, 5'd3,  1'b0);
        vecs[3]  = mk(1'b1, 1'b0, 5'd0, 1'b1, 4'd3,  5'b00110, 1'b0, 1'b0, 5'd4,  1'b0);
        vecs[4]  = mk(1'b1, 1'b0, 5'd0, 1'b1, 4'd4,  5'b00111, 1'b0, 1'b0, 5'd5,  1'b0);
        vecs[5]  = mk(1'b1, 1'b0, 5'd0, 1'b1, 4'd5,  5'b00101, 1'b0, 1'b0, 5'd6,  1'b0);
        vecs[6]  = mk(1'b1, 1'b0, 5'd0, 1'b1, 4'd6,  5'b00100, 1'b0, 1'b0, 5'd7,  1'b0);
        vecs[7]  = mk(1'b1, 1'b0, 5'd0, 1'b1, 4'd7,  5'b01100, 1'b0, 1'b0, 5'd8,  1'b0);
        vecs[8]  = mk(1'b1, 1'b0, 5'd0, 1'b1, 4'd8,  5'b01101, 1'b0, 1'b0, 5'd9,  1'b0);
        vecs[9]  = mk(1'b1, 1'b0, 5'd0, 1'b1, 4'd9,  5'b01111, 1'b0, 1'b0, 5'd10, 1'b0);
        vecs[10] = mk(1'b1, 1'b0, 5'd0, 1'b1, 4'd10, 5'b01110, 1'b0, 1'b0, 5'd11, 1'b0);
        vecs[11] = mk(1'b1, 1'b0, 5'd0, 1'b1, 4'd11, 5'b01010, 1'b0, 1'b1, 5'd12, 1'b0);
        vecs[12] = mk(1'b1, 1'b0, 5'd0, 1'b1, 4'd12, 5'b01011, 1'b0, 1'b1, 5'd13, 1'b0);
        vecs[13] = mk(1'b1, 1'b0, 5'd0, 1'b1, 4'd13, 5'b01001, 1'b0, 1'b1, 5'd14, 1'b0);
        vecs[14] = mk(1'b1, 1'b0, 5'd0, 1'b1, 4'd14, 5'b01000, 1'b0, 1'b1, 5'd15, 1'b0);
        vecs[15] = mk(1'b1, 1'b0, 5'd0, 1'b1, 4'd15, 5'b11000, 1'b1, 1'b1, 5'd16, 1'b0);
        // Write while full, clear, re-set, simultaneous set and clear.
        vecs[16] = mk(1'b1, 1'b0, 5'd0, 1'b0, 4'd0,  5'b11000, 1'b1, 1'b1, 5'd16, 1'b1);
        vecs[17] = mk(1'b0, 1'b1, 5'd0, 1'b0, 4'd0,  5'b11000, 1'b1, 1'b1, 5'd16, 1'b0);
        vecs[18] = mk(1'b1, 1'b0, 5'd0, 1'b0, 4'd0,  5'b11000, 1'b1, 1'b1, 5'd16, 1'b1);
        vecs[19] = mk(1'b1, 1'b1, 5'd0, 1'b0, 4'd0,  5'b11000, 1'b1, 1'b1, 5'd16, 1'b1);
        // One read becomes visible on the third edge.
        vecs[20] = mk(1'b0, 1'b0, 5'b00001, 1'b0, 4'd0, 5'b11000, 1'b1, 1'b1, 5'd16, 1'b1);
        vecs[21] = mk(1'b0, 1'b0, 5'b00001, 1'b0, 4'd0, 5'b11000, 1'b1, 1'b1, 5'd16, 1'b1);
        vecs[22] = mk(1'b0, 1'b0, 5'b00001, 1'b0, 4'd0, 5'b11000, 1'b0, 1'b1, 5'd15, 1'b1);
        vecs[23] = mk(1'b1, 1'b1, 5'b00001, 1'b1, 4'd0, 5'b11001, 1'b1, 1'b1, 5'd16, 1'b0);

        bus.winc = 1'b0;
        bus.wovf_clr = 1'b0;
        bus.rptr = 5'd0;
        wrst_n = 1'b1;
        #1 wrst_n = 1'b0;
        #1 chk_regs("reset", 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        chk("reset waddr", 32'(bus.waddr), 32'd0);
        repeat (2) @(posedge wclk);
        @(negedge wclk);
        wrst_n = 1'b1;
        @(posedge wclk);
        #1 chk_regs("idle", 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        chk("idle waddr", 32'(bus.waddr), 32'd0);

        for (int i = 0; i < 24; i++) begin
            @(negedge wclk);
            bus.winc = vecs[i].winc;
            bus.wovf_clr = vecs[i].clr;
            bus.rptr = vecs[i].rptr;
            #1;
            chk($sformatf("v%0d wclken", i), 32'(bus.wclken), 32'(vecs[i].en));
            chk($sformatf("v%0d waddr", i),  32'(bus.waddr),  32'(vecs[i].addr));
            @(posedge wclk);
            #1 chk_regs($sformatf("v%0d", i), vecs[i].wptr, vecs[i].full, vecs[i].alm,
                        vecs[i].fill, vecs[i].ovf);
        end

        // Overflow while full, then release ten reads so fill drops to 7.
        @(negedge wclk);
        bus.winc = 1'b1;
        bus.wovf_clr = 1'b0;
        bus.rptr = 5'b01111;
        @(posedge wclk);
        @(negedge wclk);
        bus.winc = 1'b0;
        repeat (2) @(posedge wclk);
        #1 chk_regs("pre-rst", 5'b11001, 1'b0, 1'b0, 5'd7, 1'b1);

        @(negedge wclk);
        bus.winc = 1'b1;
        #2 wrst_n = 1'b0;
        bus.rptr = 5'd0;
        #1 chk_regs("async rst", 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        chk("async rst waddr", 32'(bus.waddr), 32'd0);
        repeat (2) @(posedge wclk);
        @(negedge wclk);
        wrst_n = 1'b1;
        #1 chk("restart waddr", 32'(bus.waddr), 32'd0);
        chk("restart wclken", 32'(bus.wclken), 32'd1);
        @(posedge wclk);
        #1 chk_regs("restart", 5'b00001, 1'b0, 1'b0, 5'd1, 1'b0);
        chk("restart waddr1", 32'(bus.waddr), 32'd1);

        // Fresh start for the long burst with a reader four words behind.
        @(negedge wclk);
        bus.winc = 1'b0;
        wrst_n = 1'b0;
        @(posedge wclk);
        @(negedge wclk);
        wrst_n = 1'b1;
        prev = 5'd0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge wclk);
            rd = (k - 1 > 4) ? (k - 5) : 0;
            bus.winc = 1'b1;
            bus.rptr = tb_gray(5'(rd));
            #1;
            chk($sformatf("burst%0d waddr", k),  32'(bus.waddr),  32'((k - 1) % 16));
            chk($sformatf("burst%0d wclken", k), 32'(bus.wclken), 32'd1);
            @(posedge wclk);
            #1;
            cur = bus.wptr;
            exp_fill = k - ((k > 7) ? (k - 7) : 0);
            chk($sformatf("burst%0d onebit", k), 32'($countones(prev ^ cur)), 32'd1);
            chk($sformatf("burst%0d wptr", k),   32'(tb_g2b(cur)),  32'(k % 32));
            chk($sformatf("burst%0d wfull", k),  32'(bus.wfull),    32'd0);
            chk($sformatf("burst%0d wfill", k),  32'(bus.wfill),    32'(exp_fill));
            if (k == 32) begin
                chk("burst wrap wptr", 32'(cur), 32'd0);
            end
            prev = cur;
        end
        @(negedge wclk);
        bus.winc = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
